// File: rtl/xif_copro_result_arb.sv
// XIF coprocessor result-return stage: round-robin merge of execution and memory completions into an in-order result FIFO.
// Optional performance counters are enabled with the XIF_COPRO_RESULT_PERF_EN macro.
package xif_copro_pkg;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            addr;
    logic                  rd_is_copro;
  } copro_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  dbg;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
    logic [5:0]             ecsdata;
    logic [2:0]             ecswe;
  } x_result_t;
endpackage

module xif_copro_result_arb
  import xif_copro_pkg::*;
#(
  parameter int RESULT_FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   copro_valid_i,
  output logic                   copro_ready_o,
  input  copro_tag_t             copro_tag_i,
  input  logic [X_RFW_WIDTH-1:0] copro_data_i,
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  mem_metadata_t          mem_meta_i,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   crf_we_o,
  output logic [4:0]             crf_waddr_o,
  output logic [X_RFW_WIDTH-1:0] crf_wdata_o,
  output logic                   x_result_valid_o,
  input  logic                   x_result_ready_i,
  output x_result_t              x_result_o,
  output logic                   busy_o
`ifdef XIF_COPRO_RESULT_PERF_EN
  ,
  output logic [31:0]            perf_results_o,
  output logic [31:0]            perf_stall_o,
  output logic [31:0]            perf_conflict_o
`endif
);

  localparam int PTR_W = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESULT_FIFO_DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  x_result_t        fifo_q [RESULT_FIFO_DEPTH];
  logic             rr_q;
  logic             full, empty, conflict;
  logic             copro_push, mem_push, push, pop;
  x_result_t        push_entry;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESULT_FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(RESULT_FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign conflict = copro_valid_i & mem_valid_i;

  // Readies depend only on FIFO occupancy and the tie-break, never on downstream ready.
  assign copro_ready_o = !full & !(conflict & rr_q);
  assign mem_ready_o   = !full & !(conflict & !rr_q);
  assign copro_push    = copro_valid_i & copro_ready_o;
  assign mem_push      = mem_valid_i & mem_ready_o;
  assign push          = copro_push | mem_push;
  assign pop           = !empty & x_result_ready_i;

  always_comb begin
    push_entry = '0;
    if (copro_push) begin
      push_entry.id   = copro_tag_i.id;
      push_entry.rd   = copro_tag_i.addr;
      push_entry.data = copro_data_i;
      push_entry.we   = !copro_tag_i.rd_is_copro;
    end else begin
      push_entry.id      = mem_meta_i.id;
      push_entry.rd      = mem_meta_i.rd;
      push_entry.dbg     = mem_meta_i.dbg;
      push_entry.exc     = mem_meta_i.exc;
      push_entry.exccode = mem_meta_i.exccode;
      push_entry.data    = X_RFW_WIDTH'(mem_rdata_i);
      push_entry.err     = mem_err_i;
      push_entry.we      = mem_meta_i.we & !mem_meta_i.exc & !mem_err_i;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      if (push) wptr_q <= ptr_next(wptr_q);
      if (pop)  rptr_q <= ptr_next(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (copro_push)    rr_q <= 1'b1;
      else if (mem_push) rr_q <= 1'b0;
    end
  end

  // Coprocessor register-file write, one cycle after the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crf_we_o    <= 1'b0;
      crf_waddr_o <= '0;
      crf_wdata_o <= '0;
    end else begin
      crf_we_o <= copro_push & copro_tag_i.rd_is_copro;
      if (copro_push & copro_tag_i.rd_is_copro) begin
        crf_waddr_o <= copro_tag_i.addr;
        crf_wdata_o <= copro_data_i;
      end
    end
  end

  assign x_result_valid_o = !empty;
  assign x_result_o       = empty ? '0 : fifo_q[rptr_q];
  assign busy_o           = !empty;

`ifdef XIF_COPRO_RESULT_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != '1)) ? c + 32'd1 : c;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_results_o  <= '0;
      perf_stall_o    <= '0;
      perf_conflict_o <= '0;
    end else begin
      perf_results_o  <= sat_inc(perf_results_o, pop);
      perf_stall_o    <= sat_inc(perf_stall_o, !empty & !x_result_ready_i);
      perf_conflict_o <= sat_inc(perf_conflict_o, conflict);
    end
  end
`endif

endmodule

// File: tb/tb_xif_copro_result_arb.sv
// Directed bench for xif_copro_result_arb: ordering, arbitration, backpressure, CRF writes, mem errors, reset.
module tb_xif_copro_result_arb;
  import xif_copro_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          copro_valid, copro_ready;
  copro_tag_t    copro_tag;
  logic [31:0]   copro_data;
  logic          mem_valid, mem_ready;
  mem_metadata_t mem_meta;
  logic [31:0]   mem_rdata;
  logic          mem_err;
  logic          crf_we;
  logic [4:0]    crf_waddr;
  logic [31:0]   crf_wdata;
  logic          res_valid, res_ready;
  x_result_t     res;
  logic          busy;
`ifdef XIF_COPRO_RESULT_PERF_EN
  logic [31:0]   perf_results, perf_stall, perf_conflict;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xif_copro_result_arb #(.RESULT_FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .copro_valid_i(copro_valid), .copro_ready_o(copro_ready),
    .copro_tag_i(copro_tag), .copro_data_i(copro_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_meta_i(mem_meta), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .crf_we_o(crf_we), .crf_waddr_o(crf_waddr), .crf_wdata_o(crf_wdata),
    .x_result_valid_o(res_valid), .x_result_ready_i(res_ready),
    .x_result_o(res), .busy_o(busy)
`ifdef XIF_COPRO_RESULT_PERF_EN
    , .perf_results_o(perf_results), .perf_stall_o(perf_stall),
    .perf_conflict_o(perf_conflict)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    copro_valid = 1'b0; copro_tag = '0; copro_data = '0;
    mem_valid = 1'b0; mem_meta = '0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    res_ready = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_copro_ready", copro_ready, 1'b1);
    check_eq("rst_mem_ready", mem_ready, 1'b1);
    check_eq("rst_crf_we", crf_we, 1'b0);
    check_eq("rst_crf_waddr", crf_waddr, 5'd0);
    check_eq("rst_payload", res, '0);

    // Copro-only basic result
    copro_valid = 1'b1;
    copro_tag = '{id: 4'd3, addr: 5'd5, rd_is_copro: 1'b0};
    copro_data = 32'hDEADBEEF;
    step();
    copro_valid = 1'b0;
    check_eq("basic_valid", res_valid, 1'b1);
    check_eq("basic_id", res.id, 4'd3);
    check_eq("basic_rd", res.rd, 5'd5);
    check_eq("basic_we", res.we, 1'b1);
    check_eq("basic_data", res.data, 32'hDEADBEEF);
    check_eq("basic_exc", res.exc, 1'b0);
    step();
    check_eq("basic_valid_after", res_valid, 1'b0);
    check_eq("basic_busy_after", busy, 1'b0);

    // Round-robin tie
    do_reset();
    copro_valid = 1'b1; copro_tag = '{id: 4'd1, addr: 5'd1, rd_is_copro: 1'b0};
    mem_valid = 1'b1; mem_meta = '{id: 4'd9, rd: 5'd2, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b0};
    #1;
    check_eq("rr0_copro_ready", copro_ready, 1'b1);
    check_eq("rr0_mem_ready", mem_ready, 1'b0);
    step();
    copro_tag.id = 4'd2;
    #1;
    check_eq("rr1_head", res.id, 4'd1);
    check_eq("rr1_copro_ready", copro_ready, 1'b0);
    check_eq("rr1_mem_ready", mem_ready, 1'b1);
    step();
    mem_meta.id = 4'd10;
    check_eq("rr2_head", res.id, 4'd9);
    step();
    idle_inputs();
    check_eq("rr3_head", res.id, 4'd2);
    step();
    check_eq("rr_drained", res_valid, 1'b0);

    // Backpressure
    do_reset();
    res_ready = 1'b0;
    copro_valid = 1'b1; copro_tag = '{id: 4'd4, addr: 5'd4, rd_is_copro: 1'b0};
    copro_data = 32'hAAAA0004;
    step();
    copro_valid = 1'b0;
    mem_valid = 1'b1; mem_meta = '{id: 4'd6, rd: 5'd2, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b0};
    mem_rdata = 32'h66;
    step();
    copro_valid = 1'b1;
    #1;
    check_eq("bp_copro_ready", copro_ready, 1'b0);
    check_eq("bp_mem_ready", mem_ready, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_id", res.id, 4'd4);
      check_eq("bp_hold_data", res.data, 32'hAAAA0004);
      step();
    end
    res_ready = 1'b1;
    #1;
    check_eq("bp_drain0", res.id, 4'd4);
    step();
    check_eq("bp_drain1_id", res.id, 4'd6);
    check_eq("bp_drain1_data", res.data, 32'h66);
    step();
    check_eq("bp_empty", res_valid, 1'b0);

    // Coprocessor RF write
    do_reset();
    copro_valid = 1'b1; copro_tag = '{id: 4'd5, addr: 5'd7, rd_is_copro: 1'b1};
    copro_data = 32'h1234;
    check_eq("crf_idle", crf_we, 1'b0);
    step();
    copro_valid = 1'b0;
    check_eq("crf_we", crf_we, 1'b1);
    check_eq("crf_waddr", crf_waddr, 5'd7);
    check_eq("crf_wdata", crf_wdata, 32'h1234);
    check_eq("crf_res_valid", res_valid, 1'b1);
    check_eq("crf_res_we", res.we, 1'b0);
    step();
    check_eq("crf_we_pulse_end", crf_we, 1'b0);

    // Memory exception, bus error, clean load
    mem_valid = 1'b1;
    mem_meta = '{id: 4'd2, rd: 5'd3, we: 1'b1, exc: 1'b1, exccode: 6'd5, dbg: 1'b0};
    step();
    check_eq("exc_exc", res.exc, 1'b1);
    check_eq("exc_code", res.exccode, 6'd5);
    check_eq("exc_we", res.we, 1'b0);
    check_eq("exc_err", res.err, 1'b0);
    mem_meta = '{id: 4'd3, rd: 5'd3, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b1};
    mem_err = 1'b1; mem_rdata = 32'h77;
    step();
    check_eq("err_err", res.err, 1'b1);
    check_eq("err_we", res.we, 1'b0);
    check_eq("err_dbg", res.dbg, 1'b1);
    mem_meta = '{id: 4'd4, rd: 5'd12, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b0};
    mem_err = 1'b0; mem_rdata = 32'h55;
    step();
    mem_valid = 1'b0;
    check_eq("ld_we", res.we, 1'b1);
    check_eq("ld_rd", res.rd, 5'd12);
    check_eq("ld_data", res.data, 32'h55);
    step();

    // Reset with FIFO full and a pending CRF write
    do_reset();
    res_ready = 1'b0;
    copro_valid = 1'b1; copro_tag = '{id: 4'd1, addr: 5'd9, rd_is_copro: 1'b1};
    copro_data = 32'h99;
    step();
    copro_tag = '{id: 4'd2, addr: 5'd10, rd_is_copro: 1'b1};
    step();
    copro_valid = 1'b0;
    #1;
    check_eq("full_copro_ready", copro_ready, 1'b0);
    check_eq("full_crf_we", crf_we, 1'b1);
    check_eq("full_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", res_valid, 1'b0);
    check_eq("arst_crf_we", crf_we, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
`ifdef XIF_COPRO_RESULT_PERF_EN
    check_eq("arst_perf_results", perf_results, 32'd0);
    check_eq("arst_perf_stall", perf_stall, 32'd0);
    check_eq("arst_perf_conflict", perf_conflict, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    #1;
    check_eq("arst_copro_ready", copro_ready, 1'b1);
    check_eq("arst_mem_ready", mem_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
